// File: rtl/ipsm_pkg.sv
// Shared types and frame geometry for the pixel-to-DMEM packing path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ipsm_pkg;

    // Capture FSM states; the encoding is visible to the CPU through oSTATE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } cap_state_t;

    localparam int PIX_PER_WORD = 16;   // 256-bit word / 16-bit slot
    localparam int NUM_PIX      = 784;  // 28 x 28 image
    localparam int NUM_WORDS    = 49;   // NUM_PIX / PIX_PER_WORD

endpackage

// File: rtl/frame_word_packer_slot_accumulator.sv
// Word accumulator: writes one zero-extended pixel into an indexed slot of a wide register.
// Latency: word_o shows the current contents with this cycle's write already applied (0 cycles).
// Backpressure: none; a write and a clear on the same cycle export the full word and then empty it.
module slot_accumulator #(
    parameter int SLOT_W = 16,
    parameter int WORD_W = 256,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [7:0]        wr_pix,
    input  logic              clr,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;
    logic [WORD_W-1:0] acc_wr;

    // Apply the slot write first so a completing word can be handed out before the clear.
    always_comb begin
        acc_wr = acc_q;
        if (wr_en) begin
            acc_wr[int'(wr_idx) * SLOT_W +: SLOT_W] = {{(SLOT_W - 8){1'b0}}, wr_pix};
        end
        acc_d = clr ? '0 : acc_wr;
    end

    assign word_o = acc_wr;

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/frame_word_packer.sv
// Packs one armed 28x28 frame of 8-bit pixels into 16-bit slots, 16 per 256-bit DMEM word (build option PIXEL_INVERT_EN stores ~pixel).
// Latency: oWREN/oADDR/oDATA appear exactly 1 cycle after the 16th pixel of a word is accepted.
// Backpressure: none; the pixel stream cannot be stalled, pixels outside CAPT or past the frame are dropped.
module frame_word_packer
    import ipsm_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int SLOT_W = 16,
    parameter int WORD_W = 256,
    parameter int ADDR_W = 7
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iENABLE,
    input  logic              iSTART,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [7:0]        iDATA,
    output logic              oWREN,
    output logic [ADDR_W-1:0] oADDR,
    output logic [WORD_W-1:0] oDATA,
    output logic              oDONE,
    output logic              oERR,
    output logic [1:0]        oSTATE
);

    localparam int         IDX_W     = $clog2(WORD_W / SLOT_W);
    localparam logic [9:0] FRAME_PIX = 10'(IMG_W * IMG_H);
    localparam logic [9:0] LAST_PIX  = 10'(IMG_W * IMG_H - 1);

    cap_state_t        state_q, state_d;
    logic [9:0]        pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic              fval_q;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fval_rise;
    logic              fval_fall;
    logic              pix_take;
    logic              word_full;
    logic              acc_wr;
    logic              acc_clr;
    logic [7:0]        pix_val;
    logic [WORD_W-1:0] acc_word;

`ifdef PIXEL_INVERT_EN
    assign pix_val = ~iDATA;
`else
    assign pix_val = iDATA;
`endif

    assign fval_rise = iFVAL & ~fval_q;
    assign fval_fall = ~iFVAL & fval_q;
    // A pixel is taken only while capturing, still armed, and the frame is not yet full.
    assign pix_take  = (state_q == CAPT) && iDVAL && iENABLE && (pix_cnt_q != FRAME_PIX);
    assign word_full = pix_take && (pix_cnt_q[IDX_W-1:0] == '1);

    slot_accumulator #(
        .SLOT_W (SLOT_W),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_acc (
        .clk    (iCLK),
        .rst_n  (iRST),
        .wr_en  (acc_wr),
        .wr_idx (pix_cnt_q[IDX_W-1:0]),
        .wr_pix (pix_val),
        .clr    (acc_clr),
        .word_o (acc_word)
    );

    // Next-state, counter and registered-output logic for the capture FSM.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        word_cnt_d = word_cnt_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        acc_wr     = 1'b0;
        acc_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iENABLE && iSTART) begin
                    state_d    = ARM;
                    pix_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    acc_clr    = 1'b1;
                end
            end
            ARM: begin
                acc_clr = 1'b1;
                if (!iENABLE) begin
                    state_d = IDLE;
                end else if (fval_rise) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (!iENABLE) begin
                    // Abort: partial word dropped, nothing further written.
                    state_d = IDLE;
                    acc_clr = 1'b1;
                end else if (pix_cnt_q == FRAME_PIX) begin
                    // The final word is on the write port this cycle.
                    state_d = DONE;
                end else if (fval_fall && !(pix_take && pix_cnt_q == LAST_PIX)) begin
                    // Short frame: flag it and wait for a fresh frame at address 0.
                    state_d    = ARM;
                    err_d      = 1'b1;
                    pix_cnt_d  = '0;
                    word_cnt_d = '0;
                    acc_clr    = 1'b1;
                end else begin
                    if (pix_take) begin
                        acc_wr    = 1'b1;
                        pix_cnt_d = pix_cnt_q + 10'd1;
                    end
                    if (word_full) begin
                        wren_d     = 1'b1;
                        addr_d     = word_cnt_q;
                        data_d     = acc_word;
                        word_cnt_d = word_cnt_q + 1'b1;
                        acc_clr    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!iENABLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            fval_q     <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            fval_q     <= iFVAL;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign oWREN  = wren_q;
    assign oADDR  = addr_q;
    assign oDATA  = data_q;
    assign oDONE  = done_q;
    assign oERR   = err_q;
    assign oSTATE = state_q;

endmodule
